// File: rtl/bcd_add_sequencer.sv
// Sequencer for the digit-serial BCD adder: loads A, loads B, then walks one
// digit adder LSD-first across NUM_DIGITS digits while rippling the decimal carry.
module bcd_add_sequencer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             carry_out,
  output logic             load_a,
  output logic             load_b,
  output logic             add_en,
  output logic [IDX_W-1:0] digit_sel,
  output logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             load_a_q;
  logic             load_b_q;
  logic             add_en_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  // Strobes are registered alongside the state so each is valid for exactly
  // the cycle the FSM spends in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      add_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      add_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD_A;
            load_a_q <= 1'b1;
            busy_q   <= 1'b1;
            ovf_q    <= 1'b0;
          end
        end
        LOAD_A: begin
          state_q  <= LOAD_B;
          load_a_q <= 1'b0;
          load_b_q <= 1'b1;
        end
        LOAD_B: begin
          state_q  <= ADD;
          load_b_q <= 1'b0;
          add_en_q <= 1'b1;
          idx_q    <= '0;
          carry_q  <= 1'b0;
        end
        ADD: begin
          // Final digit: its carry becomes the overflow; index/carry return to 0.
          if (idx_q == LAST_IDX) begin
            state_q  <= DONE;
            add_en_q <= 1'b0;
            done_q   <= 1'b1;
            ovf_q    <= carry_out;
            idx_q    <= '0;
            carry_q  <= 1'b0;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            carry_q <= carry_out;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          idx_q    <= '0;
          carry_q  <= 1'b0;
          load_a_q <= 1'b0;
          load_b_q <= 1'b0;
          add_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign load_a    = load_a_q;
  assign load_b    = load_b_q;
  assign add_en    = add_en_q;
  assign digit_sel = idx_q;
  assign carry_in  = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Directed bench for bcd_add_sequencer (NUM_DIGITS=4): latency, carry ripple,
// overflow hold/clear, held start, clear aborts and async reset.
module tb_bcd_add_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       carry_out;
  logic       load_a;
  logic       load_b;
  logic       add_en;
  logic [1:0] digit_sel;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  bcd_add_sequencer #(.NUM_DIGITS(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .carry_out (carry_out),
    .load_a    (load_a),
    .load_b    (load_b),
    .add_en    (add_en),
    .digit_sel (digit_sel),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_ovf);
    chk({tag, ".strobes"}, {28'd0, load_a, load_b, add_en, done}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".sel_ci"}, {29'd0, digit_sel, carry_in}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  // Full operation: start presented just after an edge while IDLE.
  task automatic run_op(input string tag, input logic [3:0] cov,
                        input logic [3:0] exp_ci, input logic exp_ovf);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".la"}, {28'd0, load_a, load_b, add_en, done}, 32'h8);
    chk({tag, ".la_busy_ovf"}, {30'd0, busy, overflow}, 32'h2);
    tick();
    chk({tag, ".lb"}, {28'd0, load_a, load_b, add_en, done}, 32'h4);
    tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s.add%0d", tag, d), {28'd0, load_a, load_b, add_en, done}, 32'h2);
      chk($sformatf("%s.sel%0d", tag, d), {30'd0, digit_sel}, d);
      chk($sformatf("%s.ci%0d", tag, d), {31'd0, carry_in}, {31'd0, exp_ci[d]});
      carry_out = cov[d];
      tick();
    end
    carry_out = 1'b0;
    chk({tag, ".done"}, {28'd0, load_a, load_b, add_en, done}, 32'h1);
    chk({tag, ".done_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    tick();
    chk_idle({tag, ".after"}, exp_ovf);
  endtask

  int n_la, n_lb, n_add, n_done, n_ovl;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    carry_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset", 1'b0);

    // Async reset in the middle of digit 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_mid.sel", {30'd0, digit_sel}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 0123+0456, 0199+0001, 9999+0001
    run_op("nominal", 4'b0000, 4'b0000, 1'b0);
    run_op("ripple",  4'b0011, 4'b0110, 1'b0);
    run_op("ovf",     4'b1111, 4'b1110, 1'b1);
    repeat (3) tick();
    chk_idle("ovf_hold", 1'b1);
    run_op("ovf_clr", 4'b0000, 4'b0000, 1'b0);

    // Each op is 8 cycles, so 16 sampled edges of start give exactly two ops.
    n_la = 0; n_lb = 0; n_add = 0; n_done = 0; n_ovl = 0;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 15) start = 1'b0;
      n_la   += int'(load_a);
      n_lb   += int'(load_b);
      n_add  += int'(add_en);
      n_done += int'(done);
      if ((int'(load_a) + int'(load_b) + int'(add_en) + int'(done)) > 1) n_ovl++;
    end
    chk("held.load_a", n_la, 32'd2);
    chk("held.load_b", n_lb, 32'd2);
    chk("held.add_en", n_add, 32'd8);
    chk("held.done", n_done, 32'd2);
    chk("held.overlap", n_ovl, 32'd0);
    chk_idle("held.end", 1'b0);

    // Clear in IDLE drops a held overflow; clear+start in IDLE stays IDLE.
    run_op("ovf2", 4'b1111, 4'b1110, 1'b1);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk_idle("clr_idle", 1'b0);

    // Clear during LOAD_B.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("clr_lb.pre", {31'd0, load_b}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle("clr_lb", 1'b0);
    repeat (8) begin
      tick();
      chk("clr_lb.no_done", {31'd0, done | busy}, 32'd0);
    end

    // Clear on digit 1 of ADD, after a carry out of digit 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    carry_out = 1'b1;
    tick();
    carry_out = 1'b0;
    chk("clr_add.sel", {30'd0, digit_sel}, 32'd1);
    chk("clr_add.ci", {31'd0, carry_in}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle("clr_add", 1'b0);
    repeat (6) begin
      tick();
      chk("clr_add.no_done", {31'd0, done | busy}, 32'd0);
    end

    run_op("final", 4'b0101, 4'b1010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
